// File: rtl/fwd_hazard_unit.sv
// ID/EX forwarding-select and load-use stall unit for the 5-stage pipeline.
// Optional late WB->MEM store-data forwarding: FWD_HAZARD_STORE_LATE_FWD_EN.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Flush,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UsesRs,
    input  logic                  ID_UsesRt,
    input  logic                  ID_IsStore,
    input  logic [REG_ADDR_W-1:0] EX_Rd,
    input  logic                  EX_RegWrite,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] MEM_Rd,
    input  logic                  MEM_RegWrite,
    output logic                  Stall,
    output logic [1:0]            FwdA,
    output logic [1:0]            FwdB,
    output logic [1:0]            FwdSD,
    output logic [CNT_W-1:0]      StallCycles
);

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_EXM  = 2'b01;
    localparam logic [1:0] SEL_MWB  = 2'b10;
    localparam logic [1:0] SEL_LATE = 2'b11;

    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);
    localparam bit         MULTI  = (LOAD_LAT > 1);

    typedef enum logic {
        S_IDLE,
        S_STALL
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [1:0]       fwd_sd_q, fwd_sd_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;

    logic rs_ex, rs_mem;
    logic rt_ex, rt_mem;
    logic detect;
    logic stall_c;
    logic [1:0] sel_a, sel_b, sel_sd;

    function automatic logic [1:0] pick(
        input logic ex_hit,
        input logic mem_hit
    );
        logic [1:0] r;
        r = SEL_RF;
        if (ex_hit) begin
            r = SEL_EXM;
        end else if (mem_hit) begin
            r = SEL_MWB;
        end
        return r;
    endfunction

    // Register $0 is hard-wired, so it never matches a producer.
    always_comb begin
        rs_ex  = EX_RegWrite  && (EX_Rd  == ID_Rs) && (EX_Rd  != '0);
        rt_ex  = EX_RegWrite  && (EX_Rd  == ID_Rt) && (EX_Rd  != '0);
        rs_mem = MEM_RegWrite && (MEM_Rd == ID_Rs) && (MEM_Rd != '0);
        rt_mem = MEM_RegWrite && (MEM_Rd == ID_Rt) && (MEM_Rd != '0);
    end

    always_comb begin
        sel_a  = SEL_RF;
        sel_b  = SEL_RF;
        sel_sd = SEL_RF;
        if (ID_UsesRs) begin
            sel_a = pick(rs_ex, rs_mem);
        end
        if (ID_UsesRt) begin
            sel_b = pick(rt_ex, rt_mem);
        end
        if (ID_IsStore) begin
            sel_sd = pick(rt_ex, rt_mem);
`ifdef FWD_HAZARD_STORE_LATE_FWD_EN
            if (EX_MemRead && rt_ex) begin
                sel_sd = SEL_LATE;
            end
`endif
        end
    end

    // Store data alone can be picked up late in MEM when the feature is on.
    always_comb begin
        detect = 1'b0;
        if (EX_MemRead) begin
`ifdef FWD_HAZARD_STORE_LATE_FWD_EN
            detect = (ID_UsesRs && rs_ex) ||
                     (ID_UsesRt && rt_ex);
`else
            detect = (ID_UsesRs && rs_ex) ||
                     ((ID_UsesRt || ID_IsStore) && rt_ex);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        if (Flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    stall_c = detect;
                    if (detect && MULTI) begin
                        state_d = S_STALL;
                        cnt_d   = LAT_M1;
                    end
                end
                S_STALL: begin
                    stall_c = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        fwd_a_d  = sel_a;
        fwd_b_d  = sel_b;
        fwd_sd_d = sel_sd;
        if (Flush || stall_c) begin
            fwd_a_d  = SEL_RF;
            fwd_b_d  = SEL_RF;
            fwd_sd_d = SEL_RF;
        end
    end

    always_comb begin
        cyc_d = cyc_q;
        if (stall_c && (cyc_q != '1)) begin
            cyc_d = cyc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fwd_a_q  <= SEL_RF;
            fwd_b_q  <= SEL_RF;
            fwd_sd_q <= SEL_RF;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            fwd_sd_q <= fwd_sd_d;
            cyc_q    <= cyc_d;
        end
    end

    assign Stall       = Rst_n && stall_c;
    assign FwdA        = fwd_a_q;
    assign FwdB        = fwd_b_q;
    assign FwdSD       = fwd_sd_q;
    assign StallCycles = cyc_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed cases plus random traffic,
// two instances (LOAD_LAT=1/CNT_W=16 and LOAD_LAT=3/CNT_W=4).
module tb_fwd_hazard_unit;

`ifdef FWD_HAZARD_STORE_LATE_FWD_EN
    localparam bit LATE = 1'b1;
`else
    localparam bit LATE = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Flush;
    logic [4:0] ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
    logic       ID_UsesRs, ID_UsesRt, ID_IsStore;
    logic       EX_RegWrite, EX_MemRead, MEM_RegWrite;

    logic        st1, st3;
    logic [1:0]  fa1, fb1, fs1, fa3, fb3, fs3;
    logic [15:0] sc1;
    logic [3:0]  sc3;

    int n_cmp = 0;
    int n_bad = 0;

    int lat[2]  = '{1, 3};
    int cmax[2] = '{65535, 15};
    int rem[2];
    int cnt[2];
    int ea[2];
    int eb[2];
    int es[2];

    always #5 Clk = ~Clk;

    fwd_hazard_unit u1 (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_IsStore(ID_IsStore),
        .EX_Rd(EX_Rd), .EX_RegWrite(EX_RegWrite),
        .EX_MemRead(EX_MemRead),
        .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite),
        .Stall(st1), .FwdA(fa1), .FwdB(fb1), .FwdSD(fs1),
        .StallCycles(sc1)
    );

    fwd_hazard_unit #(.LOAD_LAT(3), .CNT_W(4)) u3 (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_IsStore(ID_IsStore),
        .EX_Rd(EX_Rd), .EX_RegWrite(EX_RegWrite),
        .EX_MemRead(EX_MemRead),
        .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite),
        .Stall(st3), .FwdA(fa3), .FwdB(fb3), .FwdSD(fs3),
        .StallCycles(sc3)
    );

    function automatic bit hit(int rd, bit we, int s);
        return we && (rd == s) && (rd != 0);
    endfunction

    function automatic int pick(bit ex, bit mem);
        return ex ? 1 : (mem ? 2 : 0);
    endfunction

    function automatic bit m_detect();
        bit rsx, rtx, rt_used;
        rsx = ID_UsesRs && hit(EX_Rd, EX_RegWrite, ID_Rs);
        rt_used = ID_UsesRt || (ID_IsStore && !LATE);
        rtx = rt_used && hit(EX_Rd, EX_RegWrite, ID_Rt);
        return EX_MemRead && (rsx || rtx);
    endfunction

    function automatic bit m_stall(int i);
        if (!Rst_n || Flush) return 1'b0;
        if (rem[i] > 0) return 1'b1;
        return m_detect();
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; cnt[i] = 0;
            ea[i] = 0; eb[i] = 0; es[i] = 0;
        end
    endtask

    task automatic model_update();
        bit s, rtx;
        int a, b, d;
        if (!Rst_n) begin
            model_reset();
            return;
        end
        a = ID_UsesRs ? pick(hit(EX_Rd, EX_RegWrite, ID_Rs),
                             hit(MEM_Rd, MEM_RegWrite, ID_Rs)) : 0;
        rtx = hit(EX_Rd, EX_RegWrite, ID_Rt);
        b = ID_UsesRt ? pick(rtx, hit(MEM_Rd, MEM_RegWrite, ID_Rt)) : 0;
        d = 0;
        if (ID_IsStore) begin
            d = pick(rtx, hit(MEM_Rd, MEM_RegWrite, ID_Rt));
            if (LATE && EX_MemRead && rtx) d = 3;
        end
        for (int i = 0; i < 2; i++) begin
            s = m_stall(i);
            if (s && cnt[i] < cmax[i]) cnt[i]++;
            ea[i] = (Flush || s) ? 0 : a;
            eb[i] = (Flush || s) ? 0 : b;
            es[i] = (Flush || s) ? 0 : d;
            if (Flush) rem[i] = 0;
            else if (rem[i] > 0) rem[i]--;
            else if (s) rem[i] = lat[i] - 1;
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic sample();
        @(negedge Clk);
        chk("u1.Stall", int'(st1), int'(m_stall(0)));
        chk("u1.FwdA", int'(fa1), ea[0]);
        chk("u1.FwdB", int'(fb1), eb[0]);
        chk("u1.FwdSD", int'(fs1), es[0]);
        chk("u1.StallCycles", int'(sc1), cnt[0]);
        chk("u3.Stall", int'(st3), int'(m_stall(1)));
        chk("u3.FwdA", int'(fa3), ea[1]);
        chk("u3.FwdB", int'(fb3), eb[1]);
        chk("u3.FwdSD", int'(fs3), es[1]);
        chk("u3.StallCycles", int'(sc3), cnt[1]);
    endtask

    task automatic adv();
        @(posedge Clk);
        model_update();
        #1;
    endtask

    task automatic set_in(
        input int rs, input int rt,
        input bit ur, input bit ut, input bit st,
        input int exd, input bit exw, input bit exm,
        input int md, input bit mw, input bit fl
    );
        ID_Rs = 5'(rs); ID_Rt = 5'(rt);
        ID_UsesRs = ur; ID_UsesRt = ut; ID_IsStore = st;
        EX_Rd = 5'(exd); EX_RegWrite = exw; EX_MemRead = exm;
        MEM_Rd = 5'(md); MEM_RegWrite = mw; Flush = fl;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load_use8();
        set_in(8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0);
    endtask

    initial begin
        Rst_n = 1'b0;
        idle();
        model_reset();
        sample();
        chk("rst_stall", int'(st1), 0);
        chk("rst_fwdA", int'(fa3), 0);
        chk("rst_cnt", int'(sc1), 0);
        adv();
        Rst_n = 1'b1;

        set_in(3, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0);
        sample(); chk("add_add_stall", int'(st1), 0); adv();
        set_in(0, 5, 1, 1, 0, 5, 1, 0, 5, 1, 0);
        sample(); chk("add_add_fwdA", int'(fa1), 1); adv();
        set_in(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        sample(); chk("ex_wins_fwdB", int'(fb1), 1); adv();
        idle();
        sample(); chk("r0_fwdA", int'(fa1), 0); adv();

        load_use8();
        sample();
        chk("lu_stall1", int'(st1), 1);
        chk("lu_stall3", int'(st3), 1);
        adv();
        set_in(8, 0, 1, 0, 0, 0, 0, 0, 8, 1, 0);
        sample();
        chk("lu_bubble", int'(fa1), 0);
        chk("lu_cnt1", int'(sc1), 1);
        chk("lu_release1", int'(st1), 0);
        chk("lu3_c2", int'(st3), 1);
        adv();
        sample();
        chk("lu_fwdA_mem", int'(fa1), 2);
        chk("lu3_c3", int'(st3), 1);
        adv();
        sample();
        chk("lu3_release", int'(st3), 0);
        chk("lu3_cnt", int'(sc3), 3);
        adv();

        load_use8();
        sample();
        chk("lu3_fwdA_mem", int'(fa3), 2);
        chk("lu3_again", int'(st3), 1);
        adv();
        set_in(8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 1);
        sample();
        chk("flush_stall3", int'(st3), 0);
        chk("flush_stall1", int'(st1), 0);
        adv();
        idle();
        sample();
        chk("flush_cnt3", int'(sc3), 4);
        chk("flush_idle3", int'(st3), 0);
        adv();

        set_in(2, 9, 1, 0, 1, 9, 1, 1, 0, 0, 0);
        sample();
        chk("st_ld_stall", int'(st1), LATE ? 0 : 1);
        adv();
        if (LATE) begin
            idle();
            sample(); chk("st_ld_fwdSD", int'(fs1), 3); adv();
        end else begin
            set_in(2, 9, 1, 0, 1, 0, 0, 0, 9, 1, 0);
            sample(); chk("st_ld_rel", int'(st1), 0); adv();
            idle();
            sample(); chk("st_ld_fwdSD", int'(fs1), 2); adv();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            sample(); adv();
        end

        load_use8();
        sample(); adv();
        Rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_stall", int'(st3), 0);
        chk("rst_mid_cnt", int'(sc3), 0);
        chk("rst_mid_cnt1", int'(sc1), 0);
        sample(); adv();
        Rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample(); adv();
        end
        idle();
        sample();
        chk("sat_cnt3", int'(sc3), 15);
        chk("cnt1_20", int'(sc1), 20);
        adv();

        for (int i = 0; i < 3000; i++) begin
            bit w;
            Rst_n = 1'b1;
            w = ($urandom_range(0, 3) != 0);
            set_in($urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1) != 0,
                   $urandom_range(0, 2) == 0,
                   $urandom_range(0, 3), w,
                   w && ($urandom_range(0, 1) != 0),
                   $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) begin
                Rst_n = 1'b0;
                model_reset();
            end
            sample();
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational EX-stage forwarding unit.
- Sits at the ID/EX boundary of the 5-stage MIPS pipeline.
- Decodes ID-stage source registers against in-flight producers in EX/MEM/WB and registers the forwarding selects so they are valid when the instruction enters EX.
- Generates load-use stalls of configurable length through a small state machine, and keeps a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5: register specifier width.
- LOAD_LAT, 1: bubble cycles inserted per load-use hazard (1..7).
- CNT_W, 16: width of the stall performance counter.

Ports:
- Clk  in  1  pipeline clock.
- Rst_n  in  1  asynchronous active-low reset.
- Flush  in  1  synchronous pipeline flush (branch/jump redirect).
- ID_Rs  in  REG_ADDR_W  rs of the instruction in ID.
- ID_Rt  in  REG_ADDR_W  rt of the instruction in ID.
- ID_UsesRs  in  1  ID instruction reads rs.
- ID_UsesRt  in  1  ID instruction reads rt as an ALU operand.
- ID_IsStore  in  1  ID instruction is sw/sh/sb; rt is store data.
- EX_Rd  in  REG_ADDR_W  destination of the instruction in EX.
- EX_RegWrite  in  1  EX instruction writes the register file.
- EX_MemRead  in  1  EX instruction is lw/lh/lb.
- MEM_Rd  in  REG_ADDR_W  destination in MEM.
- MEM_RegWrite  in  1  MEM instruction writes the register file.
- Stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- FwdA  out  2  registered select for EX operand A.
- FwdB  out  2  registered select for EX operand B.
- FwdSD  out  2  registered select for store data.
- StallCycles  out  CNT_W  saturating count of Stall-high cycles.

Behaviour:
- Reset (Rst_n low, async): state=IDLE, counter=0, FwdA/FwdB/FwdSD=00, StallCycles=0. Stall is 0 during reset.
- Select encoding:
  - 00: register file (register file is write-before-read).
  - 01: EX/MEM ALU result.
  - 10: MEM/WB result.
  - 11: FwdSD only, late WB->MEM store-data forward (see optional feature).
- Match rule: source S matches stage X when X_RegWrite=1, X_Rd==S and X_Rd!=0. Register $0 never matches.
- Per-source select (rs->FwdA; rt->FwdB if ID_UsesRt; rt->FwdSD if ID_IsStore):
  - 01 if the source matches EX.
  - else 10 if it matches MEM.
  - else 00.
  - The EX match (youngest producer) always wins.
- Load-use detect: EX_MemRead=1 and EX matches a used source (rs if ID_UsesRs; rt if ID_UsesRt or ID_IsStore).
- State machine IDLE/STALL, registered counter of 3 bits:
  - IDLE: Stall = detect (combinational). On detect, if LOAD_LAT>1 go to STALL with counter=LOAD_LAT-1; otherwise stay in IDLE.
  - STALL: Stall=1. Counter decrements each cycle; return to IDLE when counter reaches 1. Detect is ignored in STALL.
  - After release, a new detect in IDLE stalls again; producers have advanced, so a 10 select normally results.
- Select register update, every rising Clk edge:
  - If Flush=1 or Stall=1: FwdA/FwdB/FwdSD <= 00 (bubble in EX).
  - Otherwise they load the decoded selects.
- Latency: selects are one cycle from ID decode to EX use. Stall is same-cycle in IDLE and registered-state in STALL.
- Flush: highest priority. At the next edge state=IDLE, counter=0, selects=00. Stall is forced 0 in the Flush cycle.
- StallCycles: +1 on each edge where Stall=1; saturates at all-ones and does not wrap. Cleared only by Rst_n.
- Reset mid-stall: asynchronous return to the reset values above; no partial bubble is preserved.

Optional Feature:
- Macro: FWD_HAZARD_STORE_LATE_FWD_EN.
- Defined:
  - A load-use hazard whose only dependent source is store-data rt (ID_IsStore=1, rs not matching EX, ID_UsesRt=0) does not stall.
  - FwdSD is registered as 11; the MEM stage muxes WB data into store data.
- Undefined: that case stalls like any other load-use; FwdSD never takes value 11.

Test Plan:
- add after add: EX_Rd=3, EX_RegWrite=1, ID_Rs=3 -> Stall=0; FwdA=01 after next edge.
- Two producers: EX_Rd=5 and MEM_Rd=5 both writing, ID_Rt=5, ID_UsesRt=1 -> FwdB=01 (EX wins). $0 case: EX_Rd=0, ID_Rs=0 -> FwdA=00.
- Load-use, LOAD_LAT=1: EX_MemRead=1, EX_Rd=8, ID_Rs=8 -> Stall=1 for exactly 1 cycle, selects=00 for the bubble. Next cycle MEM_Rd=8 -> FwdA=10. StallCycles=1.
- LOAD_LAT=3, same stimulus -> Stall high for 3 consecutive cycles; StallCycles=3. Flush in the 2nd cycle -> Stall low that cycle, state IDLE, StallCycles=1.
- Store after load: EX_MemRead=1, EX_Rd=9, ID_IsStore=1, ID_Rt=9, ID_Rs=2 -> macro defined: Stall=0, FwdSD=11. Macro undefined: Stall=1 for LOAD_LAT cycles, then FwdSD=10.
- Rst_n pulsed low mid-STALL -> all outputs 0 immediately. CNT_W=4 with 20 stall cycles -> StallCycles holds at 15.
